dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width of each port and the memory.
REQ-002 SHALL have parameter DATA_W, default 16, data width of each port and the memory.
REQ-003 SHALL have parameter MAX_HOLD, default 4, the maximum number of back-to-back accesses granted to one port while the other port is waiting (range 1-15).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (DMA).
REQ-007 we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 addr0, addr1  input  ADDR_W each  access address.
REQ-009 wdata0, wdata1  input  DATA_W each  write data.
REQ-010 gnt0, gnt1  output  1 each  one-cycle pulse meaning the request was accepted and is executing this cycle.
REQ-011 rvalid0, rvalid1  output  1 each  one-cycle pulse meaning read data is valid on rdataN.
REQ-012 rdata0, rdata1  output  DATA_W each  registered read data.
REQ-013 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W  memory address and write data.
REQ-014 mem_read, mem_write  output  1 each  memory strobes.
REQ-015 mem_rdata  input  DATA_W  combinational read data from the memory.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS and RESP.
- IDLE: any reqN high -> ACCESS; otherwise stay in IDLE.
- ACCESS always -> RESP.
- RESP: any reqN high -> ACCESS; otherwise -> IDLE.
REQ-017 SHALL choose the winner on the clock edge that leaves IDLE or RESP, and latch that winner's we, addr and wdata into internal registers on the same edge.
REQ-018 SHALL, in ACCESS:
- drive mem_addr and mem_wdata from the latched registers;
- drive mem_read = !we and mem_write = we;
- pulse gntN for the winner only.
REQ-019 SHALL hold mem_read and mem_write low in IDLE and RESP, and hold mem_addr and mem_wdata at their last values.
REQ-020 SHALL, on a read, capture mem_rdata into rdataN at the end of ACCESS and pulse rvalidN during RESP (read latency 2 cycles after the arbitration edge). rdataN SHALL hold its value until the next read by that port.
REQ-021 SHALL NOT pulse rvalidN on writes; gntN is the write acknowledge.
REQ-022 Requesters SHALL hold reqN, weN, addrN and wdataN stable until they observe gntN. They may deassert reqN or present a new request in the cycle after gntN. Sustained throughput is one access per 2 cycles.
REQ-023 Arbitration from IDLE: only one port requesting -> that port; both requesting -> the port that did not win last.
REQ-024 Arbitration from RESP: hold_cnt (4-bit) counts consecutive grants to the current owner.
- Owner requesting and (other port idle or hold_cnt < MAX_HOLD-1) -> owner keeps the grant, hold_cnt++ (saturating).
- Otherwise, other port requesting -> other port wins, hold_cnt = 0.
REQ-025 The gnt0/gnt1, rvalid0/rvalid1 and mem_read/mem_write pairs SHALL each be mutually exclusive (never both high in the same cycle).
REQ-026 SHALL ignore reqN that deasserts before its grant; no access, gnt or rvalid results.

Reset
REQ-027 SHALL, on rst high at a clock edge, set:
- state = IDLE;
- last winner = port 1 (so port 0 wins the first tie);
- hold_cnt = 0;
- gnt, rvalid, rdata and the latched registers = 0;
- mem_addr and mem_wdata = 0.
REQ-028 SHALL force mem_read and mem_write low combinationally while rst is high, so reset asserted mid-ACCESS suppresses that write; an in-flight read SHALL produce no rvalid.

Configuration
REQ-029 Macro DMEM_ARB_RR_EN defined: round-robin and MAX_HOLD behaviour as in REQ-023 and REQ-024.
REQ-030 DMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins a tie, hold_cnt and MAX_HOLD logic SHALL be removed, and MAX_HOLD SHALL be ignored. Handshake timing is unchanged.

Verification
REQ-031 Single read: req0=1, we0=0, addr0=0x0001, memory holds 0x0014 at that address -> gnt0 one cycle later with mem_read=1 and mem_addr=0x0001, then rvalid0=1 with rdata0=0x0014.
REQ-032 Single write: req1=1, we1=1, addr1=0x0002, wdata1=0x00AB -> mem_write=1 for exactly one cycle with mem_addr=0x0002 and mem_wdata=0x00AB, gnt1=1, and no rvalid1.
REQ-033 Tie after reset: req0=req1=1 (reads) -> grant order is 0,1,0,1 with DMEM_ARB_RR_EN defined; 0,0,0,0 with it undefined.
REQ-034 Hold limit: MAX_HOLD=4, req0 continuously high and req1 raised during port 0's first grant -> port 0 receives 4 consecutive grants, then gnt1.
REQ-035 Reset in ACCESS of a write to 0x0003 -> mem_write=0 in that cycle, state IDLE next cycle, and the memory location unchanged.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between port 0 (CPU) and port 1 (DMA).
// Each granted access takes two cycles: ACCESS (strobe, gnt) then RESP (rvalid on reads).
// Ports: clk, rst (sync, active-high); reqN/weN/addrN/wdataN in; gntN/rvalidN/rdataN out;
//   mem_addr/mem_wdata/mem_read/mem_write to the memory; mem_rdata (combinational) back.
// Build option DMEM_ARB_RR_EN: round-robin ties plus MAX_HOLD burst limit; when undefined,
//   fixed priority (port 0 wins ties) and MAX_HOLD has no effect.
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              any_req;
    logic              win;

    assign any_req = req0 | req1;

    // Legal MAX_HOLD range is 1-15; an out-of-range value elaborates this marker block.
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_max_hold
    end

`ifdef DMEM_ARB_RR_EN
    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    logic [3:0] hold_cnt;
    logic [3:0] hold_nxt;
    logic       own_req;
    logic       oth_req;

    assign own_req = owner ? req1 : req0;
    assign oth_req = owner ? req0 : req1;

    // From RESP the current owner may keep the memory for back-to-back
    // accesses, but only MAX_HOLD in a row while the other port waits.
    always_comb begin
        win      = owner;
        hold_nxt = 4'd0;
        if (state == RESP) begin
            if (own_req && (!oth_req || hold_cnt < HOLD_LIM)) begin
                win      = owner;
                hold_nxt = (hold_cnt == 4'hF) ? hold_cnt : hold_cnt + 4'd1;
            end else begin
                win = ~owner;
            end
        end else if (req0 && req1) begin
            win = ~owner;
        end else begin
            win = req1;
        end
    end
`else
    assign win = ~req0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
`ifdef DMEM_ARB_RR_EN
            hold_cnt <= 4'd0;
`endif
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (any_req) begin
                        state   <= ACCESS;
                        owner   <= win;
                        we_q    <= win ? we1 : we0;
                        addr_q  <= win ? addr1 : addr0;
                        wdata_q <= win ? wdata1 : wdata0;
                        gnt0    <= ~win;
                        gnt1    <= win;
`ifdef DMEM_ARB_RR_EN
                        hold_cnt <= hold_nxt;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                    if (!we_q) begin
                        if (owner) begin
                            rdata1  <= mem_rdata;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= mem_rdata;
                            rvalid0 <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/data registers only load on arbitration, so they hold their
    // last values outside ACCESS. Strobes drop immediately on reset so an
    // in-flight write never lands.
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = (state == ACCESS) & ~we_q & ~rst;
    assign mem_write = (state == ACCESS) & we_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter; a transaction-level
// reference model predicts every output each cycle under directed and random traffic.
module tb_dmem_arbiter;

    localparam int AW       = 16;
    localparam int DW       = 16;
    localparam int MAX_HOLD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    // memory stand-in: 256 words, initial content addr*0x14
    logic [DW-1:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a * 16'h0014;
    endfunction

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    logic [DW-1:0] ref_mem [0:255];
    logic [1:0]    e_gnt, e_rv, p_gnt;
    logic          e_we, e_resp, last_w;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd0, e_rd1;
    int            run;

    // Check the current cycle, predict the next one from the rules, advance.
    task automatic tick();
        logic [1:0]    n_gnt, n_rv;
        logic          n_we, n_resp, acc, w;
        logic [AW-1:0] n_addr;
        logic [DW-1:0] n_wdata, n_rd0, n_rd1;
        @(negedge clk);
        acc = e_gnt[0] | e_gnt[1];
        chk("gnt0", gnt0, e_gnt[0]);
        chk("gnt1", gnt1, e_gnt[1]);
        chk("rvalid0", rvalid0, e_rv[0]);
        chk("rvalid1", rvalid1, e_rv[1]);
        chk("rdata0", rdata0, e_rd0);
        chk("rdata1", rdata1, e_rd1);
        chk("mem_read", mem_read, acc & ~e_we & ~rst);
        chk("mem_write", mem_write, acc & e_we & ~rst);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
        n_gnt   = 2'b00;
        n_rv    = 2'b00;
        n_we    = e_we;
        n_addr  = e_addr;
        n_wdata = e_wdata;
        n_rd0   = e_rd0;
        n_rd1   = e_rd1;
        n_resp  = 1'b0;
        w       = 1'b0;
        if (rst) begin
            n_we    = 1'b0;
            n_addr  = '0;
            n_wdata = '0;
            n_rd0   = '0;
            n_rd1   = '0;
            last_w  = 1'b1;
            run     = 0;
        end else if (acc) begin
            n_resp = 1'b1;
            if (e_we) begin
                ref_mem[e_addr[7:0]] = e_wdata;
            end else if (last_w) begin
                n_rv[1] = 1'b1;
                n_rd1   = ref_mem[e_addr[7:0]];
            end else begin
                n_rv[0] = 1'b1;
                n_rd0   = ref_mem[e_addr[7:0]];
            end
        end else if (req0 | req1) begin
`ifdef DMEM_ARB_RR_EN
            if (req0 && req1) begin
                if (e_resp && run < MAX_HOLD) w = last_w;
                else w = ~last_w;
            end else begin
                w = req1;
            end
            run = (e_resp && w == last_w) ? run + 1 : 1;
`else
            w = ~req0;
`endif
            last_w   = w;
            n_gnt[w] = 1'b1;
            n_we     = w ? we1 : we0;
            n_addr   = w ? addr1 : addr0;
            n_wdata  = w ? wdata1 : wdata0;
        end
        @(posedge clk);
        #1;
        p_gnt   = e_gnt;
        e_gnt   = n_gnt;
        e_rv    = n_rv;
        e_we    = n_we;
        e_addr  = n_addr;
        e_wdata = n_wdata;
        e_rd0   = n_rd0;
        e_rd1   = n_rd1;
        e_resp  = n_resp;
    endtask

    logic [1:0]    exp_tie  [4];
    logic [1:0]    exp_hold [5];
    bit            pend     [2];
    logic          rq_we    [2];
    logic [AW-1:0] rq_addr  [2];
    logic [DW-1:0] rq_wd    [2];
    int            ngr;

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef DMEM_ARB_RR_EN
        exp_tie  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_hold = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
        exp_tie  = '{2'b01, 2'b01, 2'b01, 2'b01};
        exp_hold = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_val(16'(i));
            ref_mem[i] = init_val(16'(i));
        end
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        e_gnt = 2'b00; e_rv = 2'b00; p_gnt = 2'b00;
        e_we = 1'b0; e_resp = 1'b0; last_w = 1'b1; run = 0;
        e_addr = '0; e_wdata = '0; e_rd0 = '0; e_rd1 = '0;
        tick();
        chk("rst_gnt", {gnt1, gnt0}, 2'b00);
        chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        chk("rst_rdata0", rdata0, 16'h0000);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_strobes", {mem_read, mem_write}, 2'b00);
        rst = 1'b0;

        // single read
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
        tick();
        chk("rd_gnt0", gnt0, 1'b1);
        chk("rd_mem_read", mem_read, 1'b1);
        chk("rd_mem_addr", mem_addr, 16'h0001);
        tick();
        req0 = 1'b0;
        chk("rd_rvalid0", rvalid0, 1'b1);
        chk("rd_rdata0", rdata0, 16'h0014);
        tick();

        // single write
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0002; wdata1 = 16'h00AB;
        tick();
        chk("wr_gnt1", gnt1, 1'b1);
        chk("wr_mem_write", mem_write, 1'b1);
        chk("wr_mem_addr", mem_addr, 16'h0002);
        chk("wr_mem_wdata", mem_wdata, 16'h00AB);
        tick();
        req1 = 1'b0;
        chk("wr_strobe_once", mem_write, 1'b0);
        chk("wr_no_rvalid1", rvalid1, 1'b0);
        tick();
        chk("wr_no_rvalid1_late", rvalid1, 1'b0);
        chk("wr_mem2", mem[2], 16'h00AB);

        // ties after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
            req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
            addr0 = 16'h0004; addr1 = 16'h0005;
            tick();
            chk($sformatf("tie_grant%0d", r), {gnt1, gnt0}, exp_tie[r]);
            tick();
            req0 = 1'b0; req1 = 1'b0;
            tick();
        end

        // hold limit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0011;
        ngr = 0;
        for (int c = 0; c < 20 && ngr < 5; c++) begin
            tick();
            if (gnt0 | gnt1) begin
                chk($sformatf("hold_grant%0d", ngr), {gnt1, gnt0}, exp_hold[ngr]);
                ngr++;
                req1 = 1'b1;
            end
        end
        chk("hold_grants_seen", ngr, 5);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // reset during a write access
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0003; wdata0 = 16'hBEEF;
        tick();
        chk("ra_gnt0", gnt0, 1'b1);
        rst = 1'b1;
        #1;
        chk("ra_mem_write", mem_write, 1'b0);
        tick();
        rst = 1'b0; req0 = 1'b0;
        chk("ra_idle_gnt", {gnt1, gnt0}, 2'b00);
        chk("ra_idle_strobes", {mem_read, mem_write}, 2'b00);
        tick();
        chk("ra_mem3", mem[3], init_val(16'h0003));

        // random traffic
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (p_gnt[p]) pend[p] = 1'b0;
                if (pend[p] && !e_gnt[p] && $urandom_range(0, 31) == 0) begin
                    pend[p] = 1'b0;
                end else if (!pend[p] && !e_gnt[p] && $urandom_range(0, 1) == 1) begin
                    pend[p]    = 1'b1;
                    rq_we[p]   = 1'($urandom_range(0, 1));
                    rq_addr[p] = 16'($urandom_range(0, 63));
                    rq_wd[p]   = 16'($urandom);
                end
            end
            req0 = pend[0]; we0 = rq_we[0]; addr0 = rq_addr[0]; wdata0 = rq_wd[0];
            req1 = pend[1]; we1 = rq_we[1]; addr1 = rq_addr[1]; wdata1 = rq_wd[1];
            rst  = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
